sad_best_mv_select: RTL and testbench
=====================================

# sad_best_mv_select

Consumer end of the basic-layer search SAD interface: accepts the per-position 16x16, 16x32, 32x16 and 32x32 SAD vectors emitted each search cycle together with `search_column_count`/`search_row_count`. For each of the 9 partitions it keeps a running minimum cost and the position that produced it. After the last search position it presents signed motion vectors and best SADs to the mode-decision stage.

## Interface
- `COL_CENTER`, default 16: column count for mv_x = 0.
- `ROW_CENTER`, default 64: row count for mv_y = 0.
- `LAMBDA_SHIFT`, default 2: MV-cost weight, used only under `SAD_MV_COST_EN`.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle pulse that begins a new search window.
- `sad_valid  in  1`: SAD inputs and counts valid this cycle.
- `sad_last  in  1`: qualifies the final position; meaningful only with `sad_valid`.
- `SAD16x16  in  64`: 4 x 16-bit values, index 0 at LSBs.
- `SAD16x32  in  34`: 2 x 17-bit values.
- `SAD32x16  in  34`: 2 x 17-bit values.
- `SAD32x32  in  18`: 1 x 18-bit value.
- `search_column_count  in  5`, `search_row_count  in  7`: position of the current SADs.
- `best_sad  out  9x20 (180)`: zero-extended best SAD per partition. Order: 16x16[0..3], 16x32[0..1], 32x16[0..1], 32x32.
- `best_mv  out  9x16 (144)`: per partition {mv_y[7:0], mv_x[7:0]}, two's complement.
- `busy  out  1`: high from the cycle after `start` until `done`.
- `done  out  1`: one-cycle pulse; results are valid from this cycle on.

## Operation
- States: IDLE, SEARCH, DRAIN.
  - IDLE --start--> SEARCH.
  - SEARCH --(sad_valid & sad_last)--> DRAIN.
  - DRAIN --(pipeline empty)--> IDLE, asserting `done` on that transition.
- On `start`: every min-cost register is set to all ones (20'hFFFFF), every MV register to 0, and the pipeline is flushed.
- `start` in SEARCH or DRAIN aborts the current window and restarts it. No `done` is issued for the aborted window.
- `sad_valid` in IDLE is ignored.
- Stage 1 registers the SADs, zero-extended to 20 bits, together with:
  - mv_x = col - COL_CENTER
  - mv_y = row - ROW_CENTER
  - both 8-bit signed.
- Stage 2 replaces a partition's min cost and MV when the new cost is strictly less than the stored one. On a tie, the earliest position wins.
- Cost equals SAD when the cost feature is compiled out. Cost arithmetic saturates at 20'hFFFFF and never wraps.
- `best_sad` always reports the raw SAD of the winner, never its cost.
- Outputs hold their values until the next `start`.
- A `sad_last` without `sad_valid` has no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `best_sad` all ones, `best_mv`=0. State resets to IDLE.
- An input sampled at edge N updates the minima at edge N+2.
- `done` is asserted in the cycle after the last-position update, i.e. 3 cycles after the edge that samples `sad_valid & sad_last`.
- Back-to-back `sad_valid` is supported every cycle. Gaps are allowed.
- `start` in the same cycle as `sad_valid`: `start` wins and that SAD is discarded.
- `start` in the same cycle as `done`: `done` still pulses for the finished window, and the new window begins.
- `busy` rises 1 cycle after `start` and falls in the cycle `done` is high.

## Configuration
- `SAD_MV_COST_EN` defined:
  - cost = SAD + ((|mv_x| + |mv_y|) << LAMBDA_SHIFT).
  - This is computed in stage 1 with saturation.
- Not defined:
  - cost = SAD.
  - The abs/shift logic is absent.
- Latency is identical in both builds.

## Structure
- Shared package `me_pkg` holds:
  - `NUM_PART`=9, `COST_W`=20, `MV_W`=8.
  - Partition index constants (P16x16_0 … P32x32).
  - The `mv_t` struct {y, x}.
  - The state enum.
- Sub-module `sad_min_cell`: one per partition (9 instances). It holds the cost/SAD/MV registers and performs the strict-less compare, with `clear` and `update_en` inputs.
- The top level contains the FSM, stage-1 registers, unpacking and MV/cost computation.

## Test plan
- Reset with `rst_n`=0 mid-SEARCH -> `busy`=0, `best_sad`=all ones, `best_mv`=0, and no `done` after release.
- `start`, then 4 positions: SAD32x32 = 500, 300, 300, 400 at col/row (16,64), (17,64), (18,64), (16,65), last on the 4th -> `done` 3 cycles after the last sample. 32x32 result: `best_sad`=300, `best_mv`=(y=0, x=+1); the tie keeps the earlier position.
- Position col=0, row=0 with all SADs 0 -> every mv = (y=-64, x=-16), i.e. 8'hC0 / 8'hF0.
- `start` asserted again mid-SEARCH, then one position with SAD16x16[2]=7, last -> only the new window is reflected: `best_sad`[2]=7 and exactly one `done`.
- With `SAD_MV_COST_EN`, `LAMBDA_SHIFT`=2, two positions:
  - SAD 100 at (16,64).
  - SAD 95 at (18,64), cost 103.
  - Result: winner is (0,0), `best_sad`=100.
  - Without the macro: winner is (x=+2), `best_sad`=95.
- `sad_valid` pulses in IDLE and a `sad_last` without `sad_valid` in SEARCH -> no state change and no `done`.

Source files
------------

// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : me_pkg
//  Description : Shared types and constants for the motion-estimation
//                best-MV selector. Holds the partition count, cost and MV
//                widths, partition index constants, the {y, x} MV struct,
//                the selector state enum and the saturated cost ceiling.
//  Revision    : 1.0 - initial release
// ============================================================================
package me_pkg;

  localparam int NUM_PART = 9;
  localparam int COST_W   = 20;
  localparam int MV_W     = 8;

  // Partition order used by best_sad / best_mv
  localparam int P16x16_0 = 0;
  localparam int P16x16_1 = 1;
  localparam int P16x16_2 = 2;
  localparam int P16x16_3 = 3;
  localparam int P16x32_0 = 4;
  localparam int P16x32_1 = 5;
  localparam int P32x16_0 = 6;
  localparam int P32x16_1 = 7;
  localparam int P32x32   = 8;

  localparam logic [COST_W-1:0] COST_MAX = {COST_W{1'b1}};

  typedef struct packed {
    logic [MV_W-1:0] y;
    logic [MV_W-1:0] x;
  } mv_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage : me_pkg
`default_nettype wire

// File: rtl/sad_min_cell.sv
`default_nettype none
// ============================================================================
//  Module      : sad_min_cell
//  Description : Running-minimum tracker for one partition. Keeps the lowest
//                cost seen so far plus the raw SAD and MV that produced it.
//                Replacement only on strictly lower cost, so the earliest
//                position wins a tie.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                clear        - re-arm for a new window (cost/SAD = max, MV = 0)
//                update_en    - candidate valid this cycle
//                cost, sad,mv - candidate cost, raw SAD and motion vector
//                best_sad     - raw SAD of current winner
//                best_mv      - MV of current winner
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_min_cell
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              update_en,
  input  logic [COST_W-1:0] cost,
  input  logic [COST_W-1:0] sad,
  input  mv_t               mv,
  output logic [COST_W-1:0] best_sad,
  output mv_t               best_mv
);

  logic [COST_W-1:0] min_cost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_cost <= COST_MAX;
      best_sad <= COST_MAX;
      best_mv  <= '0;
    end else if (clear) begin
      min_cost <= COST_MAX;
      best_sad <= COST_MAX;
      best_mv  <= '0;
    end else if (update_en && (cost < min_cost)) begin
      min_cost <= cost;
      best_sad <= sad;
      best_mv  <= mv;
    end
  end

endmodule : sad_min_cell
`default_nettype wire

// File: rtl/sad_best_mv_select.sv
`default_nettype none
// ============================================================================
//  Module      : sad_best_mv_select
//  Description : Consumes per-position SAD vectors from the search engine and
//                selects, for each of the 9 partitions, the position with the
//                lowest cost. Reports signed MVs and raw best SADs once the
//                final position has drained through the pipeline.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                start                 - begin (or restart) a search window
//                sad_valid, sad_last   - position valid / final position
//                SAD16x16..SAD32x32    - packed SAD vectors, index 0 at LSBs
//                search_column_count,
//                search_row_count      - position of the current SADs
//                best_sad, best_mv     - per-partition results
//                busy, done            - window in progress / results ready
//  Config      : SAD_MV_COST_EN - when defined, cost includes an MV-length
//                penalty ((|mv_x|+|mv_y|) << LAMBDA_SHIFT), saturated.
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_best_mv_select
  import me_pkg::*;
#(
  parameter int COL_CENTER   = 16,
  parameter int ROW_CENTER   = 64,
  parameter int LAMBDA_SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sad_valid,
  input  logic                       sad_last,
  input  logic [63:0]                SAD16x16,
  input  logic [33:0]                SAD16x32,
  input  logic [33:0]                SAD32x16,
  input  logic [17:0]                SAD32x32,
  input  logic [4:0]                 search_column_count,
  input  logic [6:0]                 search_row_count,
  output logic [NUM_PART*COST_W-1:0] best_sad,
  output logic [NUM_PART*2*MV_W-1:0] best_mv,
  output logic                       busy,
  output logic                       done
);

  localparam logic [MV_W-1:0] COL_C = MV_W'(COL_CENTER);
  localparam logic [MV_W-1:0] ROW_C = MV_W'(ROW_CENTER);

  state_t state;

  // ---------------------------------------------------------------------------
  // Input unpacking, zero-extended to cost width
  // ---------------------------------------------------------------------------
  logic [COST_W-1:0] in_sad [NUM_PART];
  mv_t               in_mv;

  for (genvar i = 0; i < 4; i++) begin : g_unpack_16x16
    assign in_sad[P16x16_0+i] = {4'b0, SAD16x16[16*i +: 16]};
  end
  for (genvar i = 0; i < 2; i++) begin : g_unpack_17
    assign in_sad[P16x32_0+i] = {3'b0, SAD16x32[17*i +: 17]};
    assign in_sad[P32x16_0+i] = {3'b0, SAD32x16[17*i +: 17]};
  end
  assign in_sad[P32x32] = {2'b0, SAD32x32};

  // Two's-complement offset from the search-window centre
  assign in_mv.x = {3'b0, search_column_count} - COL_C;
  assign in_mv.y = {1'b0, search_row_count} - ROW_C;

  // A start in the same cycle discards the position
  logic accept;
  assign accept = sad_valid && (state == SEARCH) && !start;

  // ---------------------------------------------------------------------------
  // Pipeline: s1 captures the position, s2 holds its cost, cells update next.
  // ---------------------------------------------------------------------------
  logic              s1_valid, s1_last, s2_valid, s2_last, upd_last;
  logic [COST_W-1:0] s1_sad  [NUM_PART];
  logic [COST_W-1:0] s2_sad  [NUM_PART];
  logic [COST_W-1:0] s2_cost [NUM_PART];
  logic [COST_W-1:0] cost_c  [NUM_PART];
  mv_t               s1_mv, s2_mv;

`ifdef SAD_MV_COST_EN
  logic [MV_W-1:0] abs_x, abs_y;
  logic [31:0]     penalty;

  assign abs_x   = s1_mv.x[MV_W-1] ? (~s1_mv.x + 1'b1) : s1_mv.x;
  assign abs_y   = s1_mv.y[MV_W-1] ? (~s1_mv.y + 1'b1) : s1_mv.y;
  assign penalty = (32'(abs_x) + 32'(abs_y)) << LAMBDA_SHIFT;

  for (genvar i = 0; i < NUM_PART; i++) begin : g_cost
    logic [31:0] sum;
    assign sum       = 32'(s1_sad[i]) + penalty;
    assign cost_c[i] = (sum > 32'(COST_MAX)) ? COST_MAX : sum[COST_W-1:0];
  end
`else
  for (genvar i = 0; i < NUM_PART; i++) begin : g_cost
    assign cost_c[i] = s1_sad[i];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mv <= '0;
      s2_mv <= '0;
      for (int i = 0; i < NUM_PART; i++) begin
        s1_sad[i]  <= '0;
        s2_sad[i]  <= '0;
        s2_cost[i] <= '0;
      end
    end else begin
      if (accept) begin
        s1_mv <= in_mv;
        for (int i = 0; i < NUM_PART; i++) s1_sad[i] <= in_sad[i];
      end
      s2_mv <= s1_mv;
      for (int i = 0; i < NUM_PART; i++) begin
        s2_sad[i]  <= s1_sad[i];
        s2_cost[i] <= cost_c[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with pipeline valid/last tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      upd_last <= 1'b0;
    end else begin
      done     <= 1'b0;
      s1_valid <= accept;
      s1_last  <= accept && sad_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_valid && s1_last;
      upd_last <= s2_valid && s2_last;
      if (start) begin
        // Restart: flush anything in flight, no done for the old window
        state    <= SEARCH;
        busy     <= 1'b1;
        s1_valid <= 1'b0;
        s1_last  <= 1'b0;
        s2_valid <= 1'b0;
        s2_last  <= 1'b0;
        upd_last <= 1'b0;
      end else begin
        case (state)
          SEARCH: if (sad_valid && sad_last) state <= DRAIN;
          DRAIN: begin
            // upd_last marks the cycle after the final cell update
            if (upd_last) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-partition minimum trackers
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_PART; i++) begin : g_cell
    mv_t cell_mv;
    sad_min_cell u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (start),
      .update_en (s2_valid),
      .cost      (s2_cost[i]),
      .sad       (s2_sad[i]),
      .mv        (s2_mv),
      .best_sad  (best_sad[COST_W*i +: COST_W]),
      .best_mv   (cell_mv)
    );
    assign best_mv[2*MV_W*i +: 2*MV_W] = cell_mv;
  end

endmodule : sad_best_mv_select
`default_nettype wire

// File: tb/tb_sad_best_mv_select.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sad_best_mv_select
//  Description : Self-checking bench for sad_best_mv_select. Directed cases
//                plus randomized windows compared against a behavioural
//                running-minimum model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_best_mv_select;

  localparam int COLC = 16;
  localparam int ROWC = 64;
  localparam int LAMBDA_MUL = 4;   // 1 << LAMBDA_SHIFT(2)

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, sad_valid, sad_last;
  logic [63:0]  SAD16x16;
  logic [33:0]  SAD16x32, SAD32x16;
  logic [17:0]  SAD32x32;
  logic [4:0]   col;
  logic [6:0]   row;
  logic [179:0] best_sad;
  logic [143:0] best_mv;
  logic         busy, done;

  always #5 clk = ~clk;

  sad_best_mv_select dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .sad_valid           (sad_valid),
    .sad_last            (sad_last),
    .SAD16x16            (SAD16x16),
    .SAD16x32            (SAD16x32),
    .SAD32x16            (SAD32x16),
    .SAD32x32            (SAD32x32),
    .search_column_count (col),
    .search_row_count    (row),
    .best_sad            (best_sad),
    .best_mv             (best_mv),
    .busy                (busy),
    .done                (done)
  );

  typedef struct packed {
    logic [161:0] sads;   // 9 x 18-bit, partition p at [18p +: 18]
    logic [4:0]   col;
    logic [6:0]   row;
  } pos_t;

  pos_t win[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  always @(posedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [179:0] got, input logic [179:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic pos_t rand_pos(input int unsigned maxv);
    pos_t ps;
    for (int p = 0; p < 9; p++) begin
      int unsigned w = (p < 4) ? 16 : ((p < 8) ? 17 : 18);
      int unsigned v = $urandom_range(maxv, 0);
      v = v & ((32'd1 << w) - 1);
      ps.sads[18*p +: 18] = 18'(v);
    end
    ps.col = 5'($urandom_range(31, 0));
    ps.row = 7'($urandom_range(127, 0));
    return ps;
  endfunction

  // Reference: scan the window in order, keep first strictly-lowest cost
  task automatic model(output logic [179:0] es, output logic [143:0] em);
    for (int p = 0; p < 9; p++) begin
      longint best = 64'hFFFFF;
      logic [19:0] bs = 20'hFFFFF;
      logic [15:0] bm = 16'h0;
      foreach (win[k]) begin
        int sad = int'(win[k].sads[18*p +: 18]);
        int mx  = int'(win[k].col) - COLC;
        int my  = int'(win[k].row) - ROWC;
        longint cost = sad;
`ifdef SAD_MV_COST_EN
        cost = sad + ((mx < 0 ? -mx : mx) + (my < 0 ? -my : my)) * LAMBDA_MUL;
        if (cost > 64'hFFFFF) cost = 64'hFFFFF;
`endif
        if (cost < best) begin
          best = cost;
          bs   = 20'(sad);
          bm   = {8'(my), 8'(mx)};
        end
      end
      es[20*p +: 20] = bs;
      em[16*p +: 16] = bm;
    end
  endtask

  task automatic check_results(input string tag);
    logic [179:0] es;
    logic [143:0] em;
    model(es, em);
    check({tag, "_sad"}, best_sad, es);
    check({tag, "_mv"}, {36'b0, best_mv}, {36'b0, em});
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    win.delete();
  endtask

  task automatic drive_pos(input pos_t ps, input bit last);
    for (int p = 0; p < 4; p++) SAD16x16[16*p +: 16] = ps.sads[18*p +: 16];
    for (int i = 0; i < 2; i++) begin
      SAD16x32[17*i +: 17] = ps.sads[18*(4+i) +: 17];
      SAD32x16[17*i +: 17] = ps.sads[18*(6+i) +: 17];
    end
    SAD32x32  = ps.sads[144 +: 18];
    col       = ps.col;
    row       = ps.row;
    sad_valid = 1'b1;
    sad_last  = last;
    @(posedge clk); #1;
    sad_valid = 1'b0;
    sad_last  = 1'b0;
    win.push_back(ps);
  endtask

  // Called right after the final position was sampled
  task automatic finish_window(input string tag);
    int k = 0;
    while (!done && k < 12) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_done_lat"}, 180'(k), 180'(3));
    check({tag, "_busy_fall"}, 180'(busy), 180'(0));
    check_results(tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 180'(done), 180'(0));
  endtask

  initial begin
    pos_t ps;
    int   d0;
    rst_n = 1'b0; start = 1'b0; sad_valid = 1'b0; sad_last = 1'b0;
    SAD16x16 = '0; SAD16x32 = '0; SAD32x16 = '0; SAD32x32 = '0;
    col = '0; row = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 180'(busy), 180'(0));
    check("rst_done", 180'(done), 180'(0));
    check("rst_sad", best_sad, {180{1'b1}});
    check("rst_mv", {36'b0, best_mv}, 180'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: tie on 32x32 keeps the earlier position
    do_start();
    check("busy_rise", 180'(busy), 180'(1));
    ps = rand_pos(1000); ps.sads[144 +: 18] = 18'd500; ps.col = 5'd16; ps.row = 7'd64; drive_pos(ps, 0);
    ps = rand_pos(1000); ps.sads[144 +: 18] = 18'd300; ps.col = 5'd17; ps.row = 7'd64; drive_pos(ps, 0);
    ps = rand_pos(1000); ps.sads[144 +: 18] = 18'd300; ps.col = 5'd18; ps.row = 7'd64; drive_pos(ps, 0);
    ps = rand_pos(1000); ps.sads[144 +: 18] = 18'd400; ps.col = 5'd16; ps.row = 7'd65; drive_pos(ps, 1);
    finish_window("tie");
    check("tie_32x32_sad", 180'(best_sad[160 +: 20]), 180'(300));
    check("tie_32x32_mv", 180'(best_mv[128 +: 16]), 180'(16'h0001));

    // Directed: corner position (0,0)
    do_start();
    ps = '0;
    drive_pos(ps, 1);
    finish_window("corner");
    check("corner_mv_all", {36'b0, best_mv}, {36'b0, {9{16'hC0F0}}});

    // Directed: restart mid-search
    d0 = done_cnt;
    do_start();
    drive_pos(rand_pos(50), 0);
    drive_pos(rand_pos(50), 0);
    do_start();
    ps = rand_pos(1000); ps.sads[36 +: 18] = 18'd7;
    drive_pos(ps, 1);
    finish_window("restart");
    check("restart_sad2", 180'(best_sad[40 +: 20]), 180'(7));
    repeat (4) @(posedge clk);
    #1;
    check("restart_one_done", 180'(done_cnt - d0), 180'(1));

    // Directed: MV cost decides between 100 at (0,0) and 95 at x=+2
    do_start();
    ps.sads = {9{18'd100}}; ps.col = 5'd16; ps.row = 7'd64; drive_pos(ps, 0);
    ps.sads = {9{18'd95}};  ps.col = 5'd18; ps.row = 7'd64; drive_pos(ps, 1);
    finish_window("cost");
`ifdef SAD_MV_COST_EN
    check("cost_sad", 180'(best_sad[160 +: 20]), 180'(100));
    check("cost_mv", 180'(best_mv[128 +: 16]), 180'(16'h0000));
`else
    check("cost_sad", 180'(best_sad[160 +: 20]), 180'(95));
    check("cost_mv", 180'(best_mv[128 +: 16]), 180'(16'h0002));
`endif

    // sad_valid in IDLE is ignored
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      sad_valid = 1'b1; sad_last = 1'b1; SAD32x32 = 18'd1; SAD16x16 = '0;
      @(posedge clk); #1;
      sad_valid = 1'b0; sad_last = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    check("idle_no_done", 180'(done_cnt - d0), 180'(0));
    check("idle_busy", 180'(busy), 180'(0));
    check_results("idle_hold");

    // sad_last without sad_valid has no effect
    do_start();
    sad_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sad_last = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("lastonly_busy", 180'(busy), 180'(1));
    check("lastonly_no_done", 180'(done_cnt - d0), 180'(0));
    drive_pos(rand_pos(5000), 1);
    finish_window("lastonly");

    // Randomized windows with gaps and mixed value ranges
    for (int w = 0; w < 25; w++) begin
      int n = $urandom_range(10, 1);
      do_start();
      for (int i = 0; i < n; i++) begin
        int unsigned maxv = (i % 3 == 0) ? 15 : ((i % 3 == 1) ? 4000 : 262143);
        repeat ($urandom_range(2, 0)) @(posedge clk);
        #1;
        drive_pos(rand_pos(maxv), i == n - 1);
      end
      finish_window($sformatf("rand%0d", w));
    end

    // Asynchronous reset in the middle of a search
    do_start();
    drive_pos(rand_pos(100), 0);
    drive_pos(rand_pos(100), 0);
    rst_n = 1'b0;
    #2;
    check("midrst_busy", 180'(busy), 180'(0));
    check("midrst_sad", best_sad, {180{1'b1}});
    check("midrst_mv", {36'b0, best_mv}, 180'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_done", 180'(done_cnt - d0), 180'(0));
    check("midrst_busy_after", 180'(busy), 180'(0));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule : tb_sad_best_mv_select
`default_nettype wire
